// File: rtl/exu_div.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU, one operation at a time.
// Build option: define DIV_FAST_PATH_EN to retire divide-by-zero and signed overflow without iterating.
package exu_div_pkg;
  localparam int XLEN                = 32;
  localparam int REG_FILE_ADDR_WIDTH = 5;
  localparam int INSTR_TAG_WIDTH     = 4;

  typedef struct packed {
    logic                           legal;
    logic                           div;
    logic                           rem;
    logic                           unsign;
    logic [XLEN-1:0]                rs1_data;
    logic [XLEN-1:0]                rs2_data;
    logic [REG_FILE_ADDR_WIDTH-1:0] rd_addr;
    logic [INSTR_TAG_WIDTH-1:0]     instr_tag;
  } idu1_out_t;
endpackage

// state | meaning
// IDLE  | no operation in flight
// CALC  | one restoring step per cycle, cnt counts XLEN-1 down to 0
// DONE  | result strobe cycle; a new accept may restart CALC here
module exu_div
  import exu_div_pkg::*;
(
  input  logic                           clk,
  input  logic                           rstn,
  input  idu1_out_t                      idu1_out,
  input  logic                           pipe_flush,
  output logic                           exu_div_busy,
  output logic                           div_wb_valid,
  output logic [XLEN-1:0]                div_wb_data,
  output logic [REG_FILE_ADDR_WIDTH-1:0] div_wb_rd_addr,
  output logic [INSTR_TAG_WIDTH-1:0]     div_wb_instr_tag
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]                     state;
  logic [1:0]                     state_nxt;
  logic [4:0]                     cnt;
  logic [XLEN:0]                  prem;
  logic [XLEN-1:0]                quo;
  logic [XLEN-1:0]                dvsr;
  logic [XLEN-1:0]                dividend;
  logic                           neg_q;
  logic                           neg_r;
  logic                           op_rem;
  logic                           is_dz;
  logic                           is_ovf;
  logic [REG_FILE_ADDR_WIDTH-1:0] rd_q;
  logic [INSTR_TAG_WIDTH-1:0]     tag_q;

  logic            accept;
  logic            in_signed;
  logic            in_dz;
  logic            in_ovf;
  logic            fast_accept;
  logic [XLEN-1:0] mag1;
  logic [XLEN-1:0] mag2;

  assign accept    = idu1_out.legal & idu1_out.div & ~pipe_flush &
                     ((state == ST_IDLE) | (state == ST_DONE));
  assign in_signed = ~idu1_out.unsign;
  assign in_dz     = (idu1_out.rs2_data == '0);
  assign in_ovf    = in_signed & (idu1_out.rs1_data == INT_MIN) & (idu1_out.rs2_data == '1);
  assign mag1      = (in_signed & idu1_out.rs1_data[XLEN-1]) ? -idu1_out.rs1_data : idu1_out.rs1_data;
  assign mag2      = (in_signed & idu1_out.rs2_data[XLEN-1]) ? -idu1_out.rs2_data : idu1_out.rs2_data;

`ifdef DIV_FAST_PATH_EN
  assign fast_accept = accept & (in_dz | in_ovf);
`else
  assign fast_accept = 1'b0;
`endif

  // One extra guard bit above the shifted remainder keeps the borrow unambiguous.
  logic [XLEN+1:0] shifted;
  logic [XLEN+1:0] diff;
  logic [XLEN:0]   prem_nxt;
  logic [XLEN-1:0] quo_nxt;

  assign shifted  = {prem, quo[XLEN-1]};
  assign diff     = shifted - {2'b00, dvsr};
  assign prem_nxt = diff[XLEN+1] ? shifted[XLEN:0] : diff[XLEN:0];
  assign quo_nxt  = {quo[XLEN-2:0], ~diff[XLEN+1]};

  function automatic logic [XLEN-1:0] fix_result(
    input logic            sel_rem,
    input logic            nq,
    input logic            nr,
    input logic            dz,
    input logic            ovf,
    input logic [XLEN-1:0] q_mag,
    input logic [XLEN-1:0] r_mag,
    input logic [XLEN-1:0] dvd
  );
    logic [XLEN-1:0] q;
    logic [XLEN-1:0] r;
    q = nq ? -q_mag : q_mag;
    r = nr ? -r_mag : r_mag;
    if (dz) begin
      q = '1;
      r = dvd;
    end else if (ovf) begin
      q = INT_MIN;
      r = '0;
    end
    return sel_rem ? r : q;
  endfunction

  logic                           calc_last;
  logic                           wb_fire;
  logic [XLEN-1:0]                wb_data;
  logic [REG_FILE_ADDR_WIDTH-1:0] wb_rd;
  logic [INSTR_TAG_WIDTH-1:0]     wb_tag;

  assign calc_last = (state == ST_CALC) & (cnt == 5'd0);
  assign wb_fire   = (calc_last & ~pipe_flush) | fast_accept;

  always_comb begin
    wb_data = '0;
    wb_rd   = rd_q;
    wb_tag  = tag_q;
    if (calc_last) begin
      wb_data = fix_result(op_rem, neg_q, neg_r, is_dz, is_ovf,
                           quo_nxt, prem_nxt[XLEN-1:0], dividend);
    end else begin
      wb_data = fix_result(idu1_out.rem, 1'b0, 1'b0, in_dz, in_ovf,
                           '0, '0, idu1_out.rs1_data);
      wb_rd   = idu1_out.rd_addr;
      wb_tag  = idu1_out.instr_tag;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (accept) state_nxt = fast_accept ? ST_DONE : ST_CALC;
        else        state_nxt = ST_IDLE;
      end
      ST_CALC: if (cnt == 5'd0) state_nxt = ST_DONE;
      default: state_nxt = ST_IDLE;
    endcase
    if (pipe_flush) state_nxt = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state            <= ST_IDLE;
      cnt              <= '0;
      prem             <= '0;
      quo              <= '0;
      dvsr             <= '0;
      dividend         <= '0;
      neg_q            <= 1'b0;
      neg_r            <= 1'b0;
      op_rem           <= 1'b0;
      is_dz            <= 1'b0;
      is_ovf           <= 1'b0;
      rd_q             <= '0;
      tag_q            <= '0;
      div_wb_valid     <= 1'b0;
      div_wb_data      <= '0;
      div_wb_rd_addr   <= '0;
      div_wb_instr_tag <= '0;
    end else begin
      state        <= state_nxt;
      div_wb_valid <= wb_fire;
      if (accept) begin
        cnt      <= 5'(XLEN-1);
        prem     <= '0;
        quo      <= mag1;
        dvsr     <= mag2;
        dividend <= idu1_out.rs1_data;
        neg_q    <= in_signed & (idu1_out.rs1_data[XLEN-1] ^ idu1_out.rs2_data[XLEN-1]);
        neg_r    <= in_signed & idu1_out.rs1_data[XLEN-1];
        op_rem   <= idu1_out.rem;
        is_dz    <= in_dz;
        is_ovf   <= in_ovf;
        rd_q     <= idu1_out.rd_addr;
        tag_q    <= idu1_out.instr_tag;
      end else if (state == ST_CALC) begin
        cnt  <= cnt - 5'd1;
        prem <= prem_nxt;
        quo  <= quo_nxt;
      end
      if (wb_fire) begin
        div_wb_data      <= wb_data;
        div_wb_rd_addr   <= wb_rd;
        div_wb_instr_tag <= wb_tag;
      end
    end
  end

  assign exu_div_busy = (state == ST_CALC);

endmodule

// File: tb/tb_exu_div.sv
// Directed bench for exu_div: arithmetic, special cases, back-to-back issue, flush and async reset.
// Honours DIV_FAST_PATH_EN for the expected latency of divide-by-zero and signed overflow.
module tb_exu_div;
  import exu_div_pkg::*;

  logic                           clk = 1'b0;
  logic                           rstn = 1'b0;
  logic                           pipe_flush = 1'b0;
  idu1_out_t                      idu1_out;
  logic                           exu_div_busy;
  logic                           div_wb_valid;
  logic [XLEN-1:0]                div_wb_data;
  logic [REG_FILE_ADDR_WIDTH-1:0] div_wb_rd_addr;
  logic [INSTR_TAG_WIDTH-1:0]     div_wb_instr_tag;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  exu_div dut (
    .clk              (clk),
    .rstn             (rstn),
    .idu1_out         (idu1_out),
    .pipe_flush       (pipe_flush),
    .exu_div_busy     (exu_div_busy),
    .div_wb_valid     (div_wb_valid),
    .div_wb_data      (div_wb_data),
    .div_wb_rd_addr   (div_wb_rd_addr),
    .div_wb_instr_tag (div_wb_instr_tag)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive_op(input logic rem_op, input logic uns, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd, input logic [3:0] tag);
    idu1_out.legal     = 1'b1;
    idu1_out.div       = 1'b1;
    idu1_out.rem       = rem_op;
    idu1_out.unsign    = uns;
    idu1_out.rs1_data  = a;
    idu1_out.rs2_data  = b;
    idu1_out.rd_addr   = rd;
    idu1_out.instr_tag = tag;
  endtask

  task automatic wait_wb(output int lat, output int busy_cnt);
    lat = 0;
    busy_cnt = 0;
    for (int n = 1; n <= 60 && lat == 0; n++) begin
      @(negedge clk);
      if (exu_div_busy) busy_cnt++;
      if (div_wb_valid) lat = n;
    end
  endtask

  function automatic int exp_lat(input logic uns, input logic [31:0] a, input logic [31:0] b);
    logic special;
    special = (b == 32'h0) | (!uns && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
`ifdef DIV_FAST_PATH_EN
    return special ? 1 : 33;
`else
    return (special === 1'bx) ? 0 : 33;
`endif
  endfunction

  task automatic check_wb(input string name, input int lat, input int busy_cnt, input int lat_exp,
                          input logic [31:0] exp, input logic [4:0] rd, input logic [3:0] tag);
    chk({name, " lat"}, 32'(lat), 32'(lat_exp));
    chk({name, " busy_cycles"}, 32'(busy_cnt), 32'(lat_exp - 1));
    chk({name, " data"}, div_wb_data, exp);
    chk({name, " rd"}, 32'(div_wb_rd_addr), 32'(rd));
    chk({name, " tag"}, 32'(div_wb_instr_tag), 32'(tag));
  endtask

  task automatic run_op(input string name, input logic rem_op, input logic uns,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [3:0] tag, input logic [31:0] exp);
    int lat;
    int bc;
    @(negedge clk);
    drive_op(rem_op, uns, a, b, rd, tag);
    @(posedge clk);
    #1 idu1_out = '0;
    wait_wb(lat, bc);
    check_wb(name, lat, bc, exp_lat(uns, a, b), exp, rd, tag);
  endtask

  task automatic count_valid(input int cycles, output int seen);
    seen = 0;
    for (int n = 0; n < cycles; n++) begin
      @(negedge clk);
      if (div_wb_valid) seen++;
    end
  endtask

  initial begin
    int lat;
    int bc;
    int seen;
    idu1_out = '0;
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst busy", 32'(exu_div_busy), 32'h0);
    chk("rst valid", 32'(div_wb_valid), 32'h0);
    chk("rst data", div_wb_data, 32'h0);
    chk("rst rd", 32'(div_wb_rd_addr), 32'h0);
    chk("rst tag", 32'(div_wb_instr_tag), 32'h0);
    rstn = 1'b1;

    // Legal non-divide must not start the unit.
    @(negedge clk);
    drive_op(1'b0, 1'b1, 32'd100, 32'd7, 5'd1, 4'd1);
    idu1_out.div = 1'b0;
    @(posedge clk);
    #1 idu1_out = '0;
    @(negedge clk);
    chk("nondiv busy", 32'(exu_div_busy), 32'h0);

    run_op("divu_100_7",  1'b0, 1'b1, 32'd100,        32'd7,          5'd1,  4'h1, 32'd14);
    run_op("remu_100_7",  1'b1, 1'b1, 32'd100,        32'd7,          5'd2,  4'h2, 32'd2);
    run_op("div_m7_2",    1'b0, 1'b0, 32'hFFFF_FFF9,  32'd2,          5'd3,  4'h3, 32'hFFFF_FFFD);
    run_op("rem_m7_2",    1'b1, 1'b0, 32'hFFFF_FFF9,  32'd2,          5'd4,  4'h4, 32'hFFFF_FFFF);
    run_op("rem_7_m2",    1'b1, 1'b0, 32'd7,          32'hFFFF_FFFE,  5'd5,  4'h5, 32'd1);
    run_op("div_ovf",     1'b0, 1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  5'd6,  4'h6, 32'h8000_0000);
    run_op("rem_ovf",     1'b1, 1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  5'd7,  4'h7, 32'h0);
    run_op("divu_5_0",    1'b0, 1'b1, 32'd5,          32'd0,          5'd8,  4'h8, 32'hFFFF_FFFF);
    run_op("remu_5_0",    1'b1, 1'b1, 32'd5,          32'd0,          5'd9,  4'h9, 32'd5);
    run_op("div_m5_0",    1'b0, 1'b0, 32'hFFFF_FFFB,  32'd0,          5'd10, 4'hA, 32'hFFFF_FFFF);
    run_op("rem_m5_0",    1'b1, 1'b0, 32'hFFFF_FFFB,  32'd0,          5'd11, 4'hB, 32'hFFFF_FFFB);
    run_op("divu_min_m1", 1'b0, 1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  5'd12, 4'hC, 32'h0);
    run_op("remu_min_m1", 1'b1, 1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  5'd13, 4'hD, 32'h8000_0000);
    run_op("divu_max_1",  1'b0, 1'b1, 32'hFFFF_FFFF,  32'd1,          5'd14, 4'hE, 32'hFFFF_FFFF);
    run_op("div_m100_m7", 1'b0, 1'b0, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  5'd15, 4'hF, 32'd14);

    // Back-to-back: second divide issued in the DONE cycle of the first.
    @(negedge clk);
    drive_op(1'b0, 1'b1, 32'd100, 32'd7, 5'd20, 4'h3);
    @(posedge clk);
    #1 idu1_out = '0;
    wait_wb(lat, bc);
    check_wb("b2b_first", lat, bc, 33, 32'd14, 5'd20, 4'h3);
    drive_op(1'b0, 1'b1, 32'd9, 32'd3, 5'd21, 4'h6);
    @(posedge clk);
    #1 idu1_out = '0;
    wait_wb(lat, bc);
    check_wb("b2b_second", lat, bc, 33, 32'd3, 5'd21, 4'h6);

    // Flush at T+10 of a divide.
    @(negedge clk);
    drive_op(1'b0, 1'b1, 32'd1000, 32'd10, 5'd22, 4'h7);
    @(posedge clk);
    #1 idu1_out = '0;
    repeat (10) @(negedge clk);
    pipe_flush = 1'b1;
    @(posedge clk);
    #1 pipe_flush = 1'b0;
    @(negedge clk);
    chk("flush busy", 32'(exu_div_busy), 32'h0);
    count_valid(40, seen);
    chk("flush no_wb", 32'(seen), 32'h0);
    run_op("post_flush", 1'b0, 1'b1, 32'd1000, 32'd10, 5'd23, 4'h8, 32'd100);

    // Asynchronous reset at T+5.
    @(negedge clk);
    drive_op(1'b0, 1'b1, 32'd100, 32'd7, 5'd24, 4'h9);
    @(posedge clk);
    #1 idu1_out = '0;
    repeat (5) @(negedge clk);
    rstn = 1'b0;
    #1;
    chk("arst busy", 32'(exu_div_busy), 32'h0);
    chk("arst valid", 32'(div_wb_valid), 32'h0);
    chk("arst data", div_wb_data, 32'h0);
    chk("arst rd", 32'(div_wb_rd_addr), 32'h0);
    chk("arst tag", 32'(div_wb_instr_tag), 32'h0);
    @(negedge clk);
    rstn = 1'b1;
    count_valid(40, seen);
    chk("arst no_wb", 32'(seen), 32'h0);
    run_op("post_reset", 1'b1, 1'b1, 32'd1000, 32'd7, 5'd25, 4'hA, 32'd6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
